// File: rtl/pe_array_kxk_acc.sv
// KxK signed fixed-point window dot product with a pipelined adder tree.
// Sums are accumulated across input channels, seeded by the bias, then rounded and saturated.
module pe_array_kxk_acc #(
  parameter int unsigned K      = 3,
  parameter int unsigned DATA_W = 16,
  parameter int unsigned FRAC_W = 8,
  parameter int unsigned ACC_W  = 48,
  parameter int unsigned CH_W   = 10
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  input  logic [K*K*DATA_W-1:0]    in_data,
  input  logic [K*K*DATA_W-1:0]    in_ker,
  input  logic [DATA_W-1:0]        in_bias,
  input  logic [CH_W-1:0]          cfg_num_ch,
  output logic                     out_valid,
  output logic [DATA_W-1:0]        out_data,
  output logic                     out_sat,
  output logic                     busy
);

  localparam int unsigned TAPS   = K * K;
  localparam int unsigned PROD_W = 2 * DATA_W;
  localparam logic signed [ACC_W-1:0] OUT_MAX = {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] OUT_MIN = {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

  logic [CH_W-1:0] ch_cnt;
  logic [CH_W-1:0] num_ch_lat;
  logic [CH_W-1:0] num_ch_eff;
  logic            beat_first;
  logic            beat_last;

  // Channel position of the current beat; a zero channel count behaves as one
  always_comb begin
    beat_first = (ch_cnt == '0);
    num_ch_eff = num_ch_lat;
    if (beat_first) begin
      num_ch_eff = (cfg_num_ch == '0) ? CH_W'(1) : cfg_num_ch;
    end
    beat_last = (ch_cnt == num_ch_eff - CH_W'(1));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ch_cnt     <= '0;
      num_ch_lat <= '0;
    end else if (in_valid) begin
      if (beat_first) begin
        num_ch_lat <= num_ch_eff;
      end
      ch_cnt <= beat_last ? '0 : ch_cnt + CH_W'(1);
    end
  end

  logic                      s1_valid, s1_first, s1_last;
  logic signed [DATA_W-1:0]  s1_bias;
  logic signed [PROD_W-1:0]  s1_prod [TAPS];
  logic                      s2_valid, s2_first, s2_last;
  logic signed [DATA_W-1:0]  s2_bias;
  logic signed [ACC_W-1:0]   s2_sum;
  logic signed [ACC_W-1:0]   tree_sum;
  logic                      s3_valid, s3_last;
  logic signed [ACC_W-1:0]   acc;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
      s3_valid <= 1'b0;
    end else begin
      s1_valid <= in_valid;
      s2_valid <= s1_valid;
      s3_valid <= s2_valid;
    end
  end

  // S1: per-tap products, with beat flags and bias riding alongside
  always_ff @(posedge clk) begin
    if (in_valid) begin
      s1_first <= beat_first;
      s1_last  <= beat_last;
      s1_bias  <= $signed(in_bias);
      for (int i = 0; i < int'(TAPS); i++) begin
        s1_prod[i] <= PROD_W'($signed(in_data[i*DATA_W +: DATA_W]))
                    * PROD_W'($signed(in_ker[i*DATA_W +: DATA_W]));
      end
    end
  end

  always_comb begin
    tree_sum = '0;
    for (int i = 0; i < int'(TAPS); i++) begin
      tree_sum = tree_sum + ACC_W'(s1_prod[i]);
    end
  end

  // S2: registered tree sum
  always_ff @(posedge clk) begin
    if (s1_valid) begin
      s2_first <= s1_first;
      s2_last  <= s1_last;
      s2_bias  <= s1_bias;
      s2_sum   <= tree_sum;
    end
  end

  // S3: a first beat restarts from the aligned bias, so windows run back to back
  always_ff @(posedge clk) begin
    if (rst) begin
      acc     <= '0;
      s3_last <= 1'b0;
    end else if (s2_valid) begin
      s3_last <= s2_last;
      acc     <= s2_first ? (ACC_W'(s2_bias) <<< FRAC_W) + s2_sum : acc + s2_sum;
    end
  end

  logic signed [ACC_W-1:0] shifted;
  logic                    clip_hi, clip_lo;
  logic [DATA_W-1:0]       clipped;

  always_comb begin
    shifted = acc >>> FRAC_W;
    clip_hi = (shifted > OUT_MAX);
    clip_lo = (shifted < OUT_MIN);
    clipped = shifted[DATA_W-1:0];
    if (clip_hi) begin
      clipped = OUT_MAX[DATA_W-1:0];
    end else if (clip_lo) begin
      clipped = OUT_MIN[DATA_W-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sat   <= 1'b0;
    end else begin
      out_valid <= s3_valid & s3_last;
      if (s3_valid && s3_last) begin
        out_data <= clipped;
        out_sat  <= clip_hi | clip_lo;
      end else begin
        out_sat  <= 1'b0;
      end
    end
  end

  assign busy = (ch_cnt != '0) | s1_valid | s2_valid | s3_valid | out_valid;

endmodule

// File: tb/tb_pe_array_kxk_acc.sv
// Directed bench for pe_array_kxk_acc: a channel-level arithmetic model predicts
// every output pulse, held value and busy state; literal results pin the model.
module tb_pe_array_kxk_acc;

  localparam int K  = 3;
  localparam int DW = 16;
  localparam int FW = 8;
  localparam int AW = 48;
  localparam int CW = 10;
  localparam int T  = K * K;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            in_valid = 1'b0;
  logic [T*DW-1:0] in_data = '0;
  logic [T*DW-1:0] in_ker = '0;
  logic [DW-1:0]   in_bias = '0;
  logic [CW-1:0]   cfg_num_ch = '0;
  logic            out_valid;
  logic [DW-1:0]   out_data;
  logic            out_sat;
  logic            busy;

  pe_array_kxk_acc #(.K(K), .DATA_W(DW), .FRAC_W(FW), .ACC_W(AW), .CH_W(CW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ker(in_ker),
    .in_bias(in_bias), .cfg_num_ch(cfg_num_ch), .out_valid(out_valid),
    .out_data(out_data), .out_sat(out_sat), .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int cyc;
    int data;
    bit sat;
  } exp_t;

  exp_t   exp_q[$];
  int     dv[T];
  int     kv[T];
  int     m_ch = 0;
  int     m_nch = 1;
  longint m_acc = 0;
  int     last_beat = -100;
  int     last_last = -100;
  int     held = 0;
  int     n_cmp = 0;
  int     n_bad = 0;
  int     obs_d[$];
  bit     obs_s[$];

  task automatic check(input string name, input longint act, input longint req);
    n_cmp++;
    if (act != req) begin
      n_bad++;
      $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, req);
    end
  endtask

  task automatic set_uniform(input int d, input int k);
    for (int i = 0; i < T; i++) begin
      dv[i] = d;
      kv[i] = k;
    end
  endtask

  // One beat; the model accumulates the window and schedules the result 3 edges later
  task automatic beat(input int bias, input int nch);
    longint dot;
    longint res;
    bit     first;
    bit     sat;
    @(negedge clk);
    dot   = 0;
    first = (m_ch == 0);
    for (int i = 0; i < T; i++) begin
      in_data[i*DW +: DW] = DW'(dv[i]);
      in_ker[i*DW +: DW]  = DW'(kv[i]);
      dot += longint'(dv[i]) * longint'(kv[i]);
    end
    in_bias    = first ? DW'(bias) : DW'(1000);
    cfg_num_ch = first ? CW'(nch) : CW'(7);
    in_valid   = 1'b1;
    if (first) begin
      m_nch = (nch == 0) ? 1 : nch;
      m_acc = longint'(bias) * (longint'(1) << FW) + dot;
    end else begin
      m_acc += dot;
    end
    m_ch++;
    last_beat = cyc + 1;
    if (m_ch == m_nch) begin
      m_ch = 0;
      last_last = cyc + 1;
      res = m_acc >>> FW;
      sat = (res > 32767) || (res < -32768);
      if (res > 32767) res = 32767;
      if (res < -32768) res = -32768;
      exp_q.push_back('{cyc + 4, int'(res), sat});
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      in_valid = 1'b0;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    in_valid = 1'b0;
    m_ch = 0;
    last_beat = -100;
    last_last = -100;
    held = 0;
    exp_q.delete();
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Per-cycle comparison against the model, away from the active edge
  always @(posedge clk) begin : cmp
    bit   ev;
    bit   exp_busy;
    exp_t e;
    #1;
    ev = (exp_q.size() > 0) && (exp_q[0].cyc == cyc);
    check("out_valid", longint'(out_valid), longint'(ev));
    if (ev) begin
      e = exp_q.pop_front();
      check("out_data", longint'($signed(out_data)), longint'(e.data));
      check("out_sat", longint'(out_sat), longint'(e.sat));
      held = e.data;
    end else begin
      check("out_data_hold", longint'($signed(out_data)), longint'(held));
      check("out_sat_idle", longint'(out_sat), 0);
    end
    exp_busy = (m_ch != 0) || (last_beat >= cyc - 2) || (last_last == cyc - 3);
    check("busy", longint'(busy), longint'(exp_busy));
    if (out_valid) begin
      obs_d.push_back(int'($signed(out_data)));
      obs_s.push_back(out_sat);
    end
  end

  int lit_d[11] = '{2304, 9472, 4608, 5120, 32767, -32768, -128, -1, 2304, 9216, 2304};
  bit lit_s[11] = '{0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0};

  initial begin
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    idle(2);

    set_uniform(256, 256);
    beat(0, 1);
    idle(5);

    beat(256, 4); beat(256, 4); beat(256, 4); beat(256, 4);
    idle(5);

    beat(0, 2);
    idle(2);
    beat(0, 2);
    beat(512, 2); beat(512, 2);
    idle(6);

    set_uniform(32767, 32767);
    beat(0, 1);
    set_uniform(-32768, 32767);
    beat(0, 1);
    idle(5);

    set_uniform(0, 256);
    dv[4] = -128;
    beat(0, 1);
    set_uniform(0, 1);
    dv[4] = -1;
    beat(0, 1);
    idle(5);

    set_uniform(256, 256);
    beat(0, 4); beat(0, 4);
    idle(1);
    do_reset();
    idle(3);
    beat(0, 1);
    idle(5);

    for (int i = 0; i < T; i++) begin
      dv[i] = i * 256;
      kv[i] = 256;
    end
    beat(0, 1);
    idle(5);

    set_uniform(256, 256);
    beat(0, 0);
    idle(10);

    check("pending_outputs", longint'(exp_q.size()), 0);
    check("result_count", longint'(obs_d.size()), 11);
    for (int i = 0; i < 11 && i < obs_d.size(); i++) begin
      check($sformatf("literal_data[%0d]", i), longint'(obs_d[i]), longint'(lit_d[i]));
      check($sformatf("literal_sat[%0d]", i), longint'(obs_s[i]), longint'(lit_s[i]));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/pe_array_kxk_acc.md
Name: pe_array_kxk_acc

Overview:
Parametrised successor of the fixed 3x3 PE array. It computes one KxK window dot product per accepted beat using signed fixed-point data. The adder tree is pipelined, and results are accumulated over a runtime-configurable number of input channels, with bias seeded on the first channel. It emits one rounded, saturated output pixel per window and sits between the line-buffer/window generator and the output writer in the conv datapath.

Parameters:
K, 3, kernel edge; window holds K*K taps, legal 1..7
DATA_W, 16, signed two's-complement width of data, kernel, bias and output
FRAC_W, 8, fractional bits of data/kernel/bias/output (Q format)
ACC_W, 48, signed accumulator width; must be >= 2*DATA_W + clog2(K*K) + CH_W
CH_W, 10, width of channel count (max 2^CH_W-1 channels per window)

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  synchronous, active-high reset
in_valid  in  1  window beat valid; always accepted (no backpressure)
in_data  in  K*K*DATA_W  window taps; tap i at bits [i*DATA_W +: DATA_W], i = row*K+col
in_ker  in  K*K*DATA_W  kernel taps, same packing
in_bias  in  DATA_W  bias; sampled only on the first beat of a window
cfg_num_ch  in  CH_W  channels per window; sampled only on the first beat of a window
out_valid  out  1  one-cycle pulse, result valid
out_data  out  DATA_W  result, Q(FRAC_W), saturated
out_sat  out  1  high with out_valid if out_data was clipped
busy  out  1  window in progress or pipeline non-empty

Behaviour:
- Reset (rst=1 at an edge): channel counter=0; all pipeline valid bits=0; accumulator=0; out_valid=0; out_data=0; out_sat=0; busy=0. Reset mid-window discards partial results; no out_valid follows.
- Channel counter ch_cnt: increments on each in_valid beat. A beat is first when ch_cnt==0. A beat is last when ch_cnt==num_ch_lat-1; ch_cnt then wraps to 0.
- num_ch_lat is latched from cfg_num_ch on the first beat. cfg_num_ch==0 is treated as 1. For a window with num_ch=1, the beat is both first and last.
- Pipeline (first/last flags and bias travel with the beat):
  - S1 (edge after beat): K*K products registered, each 2*DATA_W signed, Q(2*FRAC_W).
  - S2: adder tree sum registered, sign-extended to ACC_W.
  - S3: accumulator. If first: acc = (bias sign-extended <<< FRAC_W) + sum. Otherwise: acc = acc + sum.
- Output: a last beat sampled at edge t produces out_valid=1 during the cycle after edge t+3 (latency 3 edges from sample to registered output).
  - out_data = acc >>> FRAC_W (arithmetic shift, floor truncation), clipped to [-2^(DATA_W-1), 2^(DATA_W-1)-1].
  - out_sat=1 iff clipping occurred.
  - out_data holds its value until the next out_valid; out_sat clears when out_valid deasserts.
- in_valid gaps are allowed anywhere. Bubbles propagate and the accumulator holds.
- Back-to-back windows: the first beat of window N+1 may immediately follow the last beat of window N. S3 restarts from bias with no dead cycle, so full throughput is 1 window-channel/cycle.
- busy = (ch_cnt!=0) | any S1..S3 valid | out_valid.
- Accumulator overflow is not possible when the ACC_W rule holds. A violation of the rule is the user's error, not detected.

Test Plan:
- K=3, FRAC_W=8, cfg_num_ch=1, all taps data=256, ker=256, bias=0 -> one out_valid exactly 3 edges after the beat, out_data=2304 (9.0), out_sat=0.
- cfg_num_ch=4, same taps, bias=256, four consecutive beats -> single out_valid after the 4th beat, out_data=9472 (37.0); no out_valid on beats 1-3.
- Two windows back-to-back (num_ch=2, bias 0 then 512), with a 2-cycle in_valid gap inside window 1 -> outputs 4608 then 5120, and the second accumulation does not carry the first.
- data=32767, ker=32767 all taps, num_ch=1 -> out_data=32767, out_sat=1. Then data=-32768, ker=32767 -> out_data=-32768, out_sat=1.
- Truncation: single tap nonzero, data=-128 (-0.5), ker=256 -> out_data=-128. Then data=-1, ker=1 -> out_data=-1 (floor), out_sat=0.
- Assert rst for 1 cycle after 2 of 4 beats, then start a fresh num_ch=1 window -> no stale output; only the fresh result appears, busy=0 during and after reset until the new beat.
